// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetch-side and RAM-side handshake bundle for the instruction cache
interface icache_if;
    logic        if_read;
    logic [31:0] if_addr;
    logic        if_cancel;
    logic        if_busy;
    logic        if_ready;
    logic [31:0] if_data;
    logic        ram_read;
    logic [31:0] ram_addr;
    logic        ram_busy;
    logic        ram_ready;
    logic [31:0] ram_data;

    modport slave (
        input  if_read, if_addr, if_cancel, ram_busy, ram_ready, ram_data,
        output if_busy, if_ready, if_data, ram_read, ram_addr
    );

    modport master (
        output if_read, if_addr, if_cancel, ram_busy, ram_ready, ram_data,
        input  if_busy, if_ready, if_data, ram_read, ram_addr
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped instruction cache, one 32-bit word per line
module icache #(
    parameter int ADDR_WIDTH = 18,
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = ADDR_WIDTH - 2 - INDEX_BITS
) (
    input  logic      clock,
    input  logic      reset,
    icache_if.slave   bus
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {IDLE, LOOKUP, MISS, DROP} state_t;

    state_t              state_q, state_d;
    logic [31:0]         addr_q, addr_d;
    logic                if_ready_q, if_ready_d;
    logic [31:0]         if_data_q, if_data_d;
    logic                ram_read_q, ram_read_d;
    logic [31:0]         ram_addr_q, ram_addr_d;
    logic [LINES-1:0]    valid_q, valid_d;

    logic [31:0]         data_mem [LINES];
    logic [TAG_BITS-1:0] tag_mem  [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;
    logic                  fill_en;
    logic                  unused_bits;

    assign idx         = addr_q[INDEX_BITS+1:2];
    assign tag         = addr_q[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit         = valid_q[idx] && (tag_mem[idx] == tag);
    assign unused_bits = ^{bus.ram_busy, addr_q[1:0]};

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        if_ready_d = 1'b0;
        if_data_d  = if_data_q;
        ram_read_d = ram_read_q;
        ram_addr_d = ram_addr_q;
        valid_d    = valid_q;
        fill_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_read && !bus.if_cancel) begin
                    addr_d  = bus.if_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (bus.if_cancel) begin
                    state_d = IDLE;
                end else if (hit) begin
                    if_ready_d = 1'b1;
                    if_data_d  = data_mem[idx];
                    state_d    = IDLE;
                end else begin
                    ram_read_d = 1'b1;
                    ram_addr_d = {addr_q[31:2], 2'b00};
                    state_d    = MISS;
                end
            end
            MISS: begin
                if (bus.ram_ready) begin
                    fill_en      = 1'b1;
                    valid_d[idx] = 1'b1;
                    ram_read_d   = 1'b0;
                    state_d      = IDLE;
                    if (!bus.if_cancel) begin
                        if_ready_d = 1'b1;
                        if_data_d  = bus.ram_data;
                    end
                end else if (bus.if_cancel) begin
                    // The controller cannot abort, so keep the read up and fill quietly.
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.ram_ready) begin
                    fill_en      = 1'b1;
                    valid_d[idx] = 1'b1;
                    ram_read_d   = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            if_ready_q <= 1'b0;
            if_data_q  <= '0;
            ram_read_q <= 1'b0;
            ram_addr_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            if_ready_q <= if_ready_d;
            if_data_q  <= if_data_d;
            ram_read_q <= ram_read_d;
            ram_addr_q <= ram_addr_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (fill_en) begin
            data_mem[idx] <= bus.ram_data;
            tag_mem[idx]  <= tag;
        end
    end

    assign bus.if_busy  = (state_q != IDLE);
    assign bus.if_ready = if_ready_q;
    assign bus.if_data  = if_data_q;
    assign bus.ram_read = ram_read_q;
    assign bus.ram_addr = ram_addr_q;
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - randomized self-checking bench for icache against a line-table model
module tb_icache;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    icache_if bus ();

    icache dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ram_reads = 0;
    logic ram_read_prev = 1'b0;

    // Model: per-line valid/tag/data, backing memory keyed by word address.
    bit          valid_m [128];
    logic [8:0]  tag_m   [128];
    logic [31:0] data_m  [128];
    logic [31:0] ram_m   [logic [31:0]];
    logic [31:0] last_data = '0;

    always @(posedge clock) begin
        if (bus.ram_read && !ram_read_prev) ram_reads++;
        ram_read_prev = bus.ram_read;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (ram_m.exists(w)) return ram_m[w];
        return {w[15:0], ~w[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    // cancel_at: -1 none, 0 in LOOKUP, k>=1 k cycles into the miss (k==lat coincides with ram_ready)
    task automatic do_fetch(input logic [31:0] addr, input int cancel_at, input int lat);
        int          idx;
        logic [8:0]  tg;
        bit          hit;
        bit          exp_rdy;
        int          r0;
        logic [31:0] w;
        idx = int'(addr[8:2]);
        tg  = addr[17:9];
        hit = valid_m[idx] && (tag_m[idx] == tg);
        r0  = ram_reads;
        bus.if_read = 1'b1;
        bus.if_addr = addr;
        step();
        bus.if_read = 1'b0;
        check("lookup_busy", 32'(bus.if_busy), 32'd1);
        check("lookup_rdy", 32'(bus.if_ready), 32'd0);
        if (cancel_at == 0) bus.if_cancel = 1'b1;
        step();
        bus.if_cancel = 1'b0;
        if (cancel_at == 0) begin
            check("cancel_lookup_rdy", 32'(bus.if_ready), 32'd0);
            check("cancel_lookup_busy", 32'(bus.if_busy), 32'd0);
            check("cancel_lookup_ram", 32'(bus.ram_read), 32'd0);
        end else if (hit) begin
            check("hit_rdy", 32'(bus.if_ready), 32'd1);
            check("hit_data", bus.if_data, data_m[idx]);
            check("hit_ram_read", 32'(bus.ram_read), 32'd0);
            check("hit_busy", 32'(bus.if_busy), 32'd0);
            last_data = data_m[idx];
            step();
            check("rdy_pulse", 32'(bus.if_ready), 32'd0);
            check("data_hold", bus.if_data, last_data);
        end else begin
            w = ram_word(addr);
            check("miss_ram_read", 32'(bus.ram_read), 32'd1);
            check("miss_ram_addr", bus.ram_addr, {addr[31:2], 2'b00});
            for (int c = 1; c <= lat; c++) begin
                bus.if_cancel = (c == cancel_at);
                bus.ram_ready = (c == lat);
                bus.ram_busy  = 1'b1;
                bus.ram_data  = (c == lat) ? w : $urandom;
                step();
                bus.if_cancel = 1'b0;
                bus.ram_ready = 1'b0;
                if (c < lat) begin
                    check("miss_hold_read", 32'(bus.ram_read), 32'd1);
                    check("miss_hold_addr", bus.ram_addr, {addr[31:2], 2'b00});
                    check("miss_no_rdy", 32'(bus.if_ready), 32'd0);
                end
            end
            bus.ram_busy = 1'b0;
            exp_rdy = (cancel_at < 1);
            check("fill_ram_read", 32'(bus.ram_read), 32'd0);
            check("fill_busy", 32'(bus.if_busy), 32'd0);
            check("fill_rdy", 32'(bus.if_ready), 32'(exp_rdy));
            if (exp_rdy) begin
                check("fill_data", bus.if_data, w);
                last_data = w;
            end else begin
                check("cancel_data_hold", bus.if_data, last_data);
            end
            valid_m[idx] = 1'b1;
            tag_m[idx]   = tg;
            data_m[idx]  = w;
            step();
            check("rdy_pulse", 32'(bus.if_ready), 32'd0);
            check("data_hold", bus.if_data, last_data);
        end
        check("ram_txn_count", 32'(ram_reads - r0), (!hit && cancel_at != 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          ca;
        int          lat;
        bus.if_read   = 1'b0;
        bus.if_addr   = '0;
        bus.if_cancel = 1'b0;
        bus.ram_busy  = 1'b0;
        bus.ram_ready = 1'b0;
        bus.ram_data  = '0;
        for (int i = 0; i < 128; i++) valid_m[i] = 1'b0;
        ram_m[32'h0000_1000] = 32'h00A0_0093;
        ram_m[32'h0000_2000] = 32'h1234_5678;

        step(); step(); step();
        check("rst_rdy", 32'(bus.if_ready), 32'd0);
        check("rst_data", bus.if_data, 32'd0);
        check("rst_ram_read", 32'(bus.ram_read), 32'd0);
        check("rst_ram_addr", bus.ram_addr, 32'd0);
        reset = 1'b0;
        step();
        check("idle_busy", 32'(bus.if_busy), 32'd0);

        do_fetch(32'h0000_1000, -1, 5);
        do_fetch(32'h0000_1000, -1, 3);
        do_fetch(32'h0000_1200, -1, 2);
        do_fetch(32'h0000_1000, -1, 2);
        do_fetch(32'h0000_2000, 2, 5);
        do_fetch(32'h0000_2000, -1, 3);

        bus.if_read   = 1'b1;
        bus.if_cancel = 1'b1;
        bus.if_addr   = 32'h0000_4000;
        step();
        bus.if_read   = 1'b0;
        bus.if_cancel = 1'b0;
        check("idle_cancel_busy", 32'(bus.if_busy), 32'd0);
        step();
        check("idle_cancel_busy2", 32'(bus.if_busy), 32'd0);
        check("idle_cancel_ram", 32'(bus.ram_read), 32'd0);
        do_fetch(32'h0000_2000, 0, 1);
        do_fetch(32'h0000_3000, 4, 4);
        do_fetch(32'h0000_3000, -1, 2);

        bus.if_read = 1'b1;
        bus.if_addr = 32'h0000_5004;
        step();
        bus.if_read = 1'b0;
        step();
        check("pre_rst_ram_read", 32'(bus.ram_read), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midmiss_rst_ram_read", 32'(bus.ram_read), 32'd0);
        check("midmiss_rst_busy", 32'(bus.if_busy), 32'd0);
        check("midmiss_rst_ram_addr", bus.ram_addr, 32'd0);
        check("midmiss_rst_data", bus.if_data, 32'd0);
        for (int i = 0; i < 128; i++) valid_m[i] = 1'b0;
        last_data = '0;
        step();
        do_fetch(32'h0000_1000, -1, 3);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFC_0000) : 32'h0;
            a = a | (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 7)) << 2)
                  | 32'($urandom_range(0, 3));
            lat = $urandom_range(1, 6);
            case ($urandom_range(0, 7))
                0:       ca = 0;
                1:       ca = $urandom_range(1, lat);
                default: ca = -1;
            endcase
            do_fetch(a, ca, lat);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
